accum_arbiter: RTL



---
 rtl/accum_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/accum_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | accum_arbiter                                                            |
// | Round-robin arbiter sharing one burst accumulator between A and B.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module accum_arbiter #(
  parameter int NB_IN  = 4,
  parameter int NB_SUM = 6,
  parameter int NB_LEN = 4
) (
  input  logic              clock,
  input  logic              i_rst_n,
  input  logic              i_req_a,
  input  logic              i_req_b,
  input  logic [NB_LEN-1:0] i_len_a,
  input  logic [NB_LEN-1:0] i_len_b,
  input  logic [NB_IN-1:0]  i_data_a,
  input  logic [NB_IN-1:0]  i_data_b,
  input  logic              i_valid_a,
  input  logic              i_valid_b,
  output logic              o_ready_a,
  output logic              o_ready_b,
  output logic [1:0]        o_grant,
  output logic [NB_SUM-1:0] o_data,
  output logic              o_overflow,
  output logic              o_id,
  output logic              o_res_valid,
  input  logic              i_res_ack
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_grant;
  logic                r_id;
  logic                r_last;
  logic [NB_LEN:0]     r_cnt;
  logic [NB_SUM-1:0]   r_sum;
  logic                r_ovf;

  logic                w_win;
  logic [NB_LEN-1:0]   w_len_sel;
  logic                w_gnt_req;
  logic                w_gnt_valid;
  logic [NB_IN-1:0]    w_gnt_data;
  logic                w_beat;
  logic                w_last_beat;
  logic                w_start;
  logic                w_abort;
  logic                w_ack;
  logic [NB_SUM:0]     w_sum_add;

  // On a tie the requester that was not served last wins (0 = A, 1 = B).
  assign w_win       = (i_req_a && i_req_b) ? ~r_last : i_req_b;
  assign w_len_sel   = w_win ? i_len_b : i_len_a;
  assign w_gnt_req   = r_id ? i_req_b   : i_req_a;
  assign w_gnt_valid = r_id ? i_valid_b : i_valid_a;
  assign w_gnt_data  = r_id ? i_data_b  : i_data_a;
  assign w_beat      = (r_state == ST_ACCUM) && w_gnt_valid;
  assign w_last_beat = w_beat && (r_cnt == (NB_LEN+1)'(1));
  assign w_sum_add   = {1'b0, r_sum} + {{(NB_SUM+1-NB_IN){1'b0}}, w_gnt_data};

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_ack       = 1'b0;
    o_ready_a   = 1'b0;
    o_ready_b   = 1'b0;
    o_res_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_a || i_req_b) begin
          w_start     = 1'b1;
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        o_ready_a = r_grant[0];
        o_ready_b = r_grant[1];
        if (w_last_beat) begin
          w_state_nxt = ST_RESULT;
        end else if (!w_gnt_req && !w_beat) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RESULT: begin
        o_res_valid = 1'b1;
        if (i_res_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant <= 2'b00;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_start) begin
        r_grant <= w_win ? 2'b10 : 2'b01;
        r_id    <= w_win;
        // A zero length field encodes the maximum burst of 2**NB_LEN beats.
        r_cnt   <= (w_len_sel == '0) ? {1'b1, {NB_LEN{1'b0}}} : {1'b0, w_len_sel};
        r_sum   <= '0;
        r_ovf   <= 1'b0;
      end
      if (w_beat) begin
        r_sum <= w_sum_add[NB_SUM-1:0];
        r_ovf <= r_ovf | w_sum_add[NB_SUM];
        r_cnt <= r_cnt - (NB_LEN+1)'(1);
        if (w_last_beat) begin
          r_grant <= 2'b00;
        end
      end
      if (w_abort) begin
        r_grant <= 2'b00;
        r_last  <= r_id;
        r_sum   <= '0;
        r_ovf   <= 1'b0;
      end
      if (w_ack) begin
        r_last <= r_id;
      end
    end
  end

  assign o_grant    = r_grant;
  assign o_data     = r_sum;
  assign o_overflow = r_ovf;
  assign o_id       = r_id;

endmodule
`default_nettype wire
